// File: rtl/sap_ctrl_pkg.sv
// Shared encodings for the SAP control sequencer: opcodes, one-hot
// T-state values and bit positions inside the internal control word.
package sap_ctrl_pkg;

  localparam logic [3:0] OP_LDA = 4'h0;
  localparam logic [3:0] OP_ADD = 4'h1;
  localparam logic [3:0] OP_SUB = 4'h2;
  localparam logic [3:0] OP_JC  = 4'h7;
  localparam logic [3:0] OP_OUT = 4'hE;
  localparam logic [3:0] OP_HLT = 4'hF;

  localparam int unsigned T_W = 6;

  localparam logic [T_W-1:0] T1 = 6'b000001;
  localparam logic [T_W-1:0] T2 = 6'b000010;
  localparam logic [T_W-1:0] T3 = 6'b000100;
  localparam logic [T_W-1:0] T4 = 6'b001000;
  localparam logic [T_W-1:0] T5 = 6'b010000;
  localparam logic [T_W-1:0] T6 = 6'b100000;

  // Control word bit positions.
  localparam int unsigned CW_EP     = 0;
  localparam int unsigned CW_PC_INC = 1;
  localparam int unsigned CW_LP     = 2;
  localparam int unsigned CW_LM     = 3;
  localparam int unsigned CW_CE     = 4;
  localparam int unsigned CW_LI     = 5;
  localparam int unsigned CW_EI     = 6;
  localparam int unsigned CW_LA     = 7;
  localparam int unsigned CW_EA     = 8;
  localparam int unsigned CW_LB     = 9;
  localparam int unsigned CW_SUB    = 10;
  localparam int unsigned CW_EV     = 11;
  localparam int unsigned CW_LO     = 12;
  localparam int unsigned CW_W      = 13;

  // Sequencer mode: running the T-state ring, or stopped after HLT.
  typedef enum logic {
    MODE_RUN  = 1'b0,
    MODE_HALT = 1'b1
  } mode_e;

endpackage

// File: rtl/sap_ring_counter.sv
// Six-bit one-hot T-state ring. Synchronous reset to T1; hold freezes it.
module sap_ring_counter
  import sap_ctrl_pkg::*;
(
  input  logic           clk,
  input  logic           reset,
  input  logic           hold,
  output logic [T_W-1:0] ring
);

  // Rotate one position per cycle unless held; reset always wins.
  always_ff @(posedge clk) begin
    if (reset) begin
      ring <= T1;
    end else if (!hold) begin
      ring <= {ring[T_W-2:0], ring[T_W-1]};
    end
  end

endmodule

// File: rtl/sap_control_sequencer.sv
// SAP control sequencer: HALT mode register plus combinational decode of
// the control word from the T-state ring and the IR opcode.
// Optional feature macro: SAP_CTRL_JC_EN (decodes JC, opcode 4'h7).
module sap_control_sequencer
  import sap_ctrl_pkg::*;
(
  input  logic           clk,
  input  logic           reset,
  input  logic [3:0]     opcode,
  input  logic           cmp_flag,
  output logic           ep,
  output logic           pc_inc,
  output logic           lp,
  output logic           lm,
  output logic           ce,
  output logic           li,
  output logic           ei,
  output logic           la,
  output logic           ea,
  output logic           lb,
  output logic           sub,
  output logic           ev,
  output logic           lo,
  output logic [T_W-1:0] t_state,
  output logic           halted
);

  mode_e           mode_q, mode_d;
  logic [T_W-1:0]  ring;
  logic [CW_W-1:0] cw;

  // Once halted the ring is frozen; its value is hidden until reset.
  sap_ring_counter u_ring (
    .clk   (clk),
    .reset (reset),
    .hold  (mode_q == MODE_HALT),
    .ring  (ring)
  );

  // Mode register: leaves HALT only through reset.
  always_ff @(posedge clk) begin
    if (reset) mode_q <= MODE_RUN;
    else       mode_q <= mode_d;
  end

  // Next mode: HLT in T4 stops the sequencer at the edge ending T4.
  always_comb begin
    mode_d = mode_q;
    if (mode_q == MODE_RUN && ring == T4 && opcode == OP_HLT) mode_d = MODE_HALT;
  end

  // Control word decode; all zero during reset and in HALT.
  always_comb begin
    cw = '0;
    if (!reset && mode_q == MODE_RUN) begin
      case (ring)
        T1: begin cw[CW_EP] = 1'b1; cw[CW_LM] = 1'b1; end
        T2: cw[CW_PC_INC] = 1'b1;
        T3: begin cw[CW_CE] = 1'b1; cw[CW_LI] = 1'b1; end
        T4: begin
          case (opcode)
            OP_LDA, OP_ADD, OP_SUB: begin cw[CW_EI] = 1'b1; cw[CW_LM] = 1'b1; end
            OP_OUT: begin cw[CW_EA] = 1'b1; cw[CW_LO] = 1'b1; end
`ifdef SAP_CTRL_JC_EN
            OP_JC: begin
              if (cmp_flag) begin cw[CW_EI] = 1'b1; cw[CW_LP] = 1'b1; end
            end
`endif
            default: ;
          endcase
        end
        T5: begin
          case (opcode)
            OP_LDA: begin cw[CW_CE] = 1'b1; cw[CW_LA] = 1'b1; end
            OP_ADD: begin cw[CW_CE] = 1'b1; cw[CW_LB] = 1'b1; end
            OP_SUB: begin cw[CW_CE] = 1'b1; cw[CW_LB] = 1'b1; cw[CW_SUB] = 1'b1; end
            default: ;
          endcase
        end
        T6: begin
          case (opcode)
            OP_ADD: begin cw[CW_EV] = 1'b1; cw[CW_LA] = 1'b1; end
            OP_SUB: begin cw[CW_EV] = 1'b1; cw[CW_LA] = 1'b1; cw[CW_SUB] = 1'b1; end
            default: ;
          endcase
        end
        default: ;
      endcase
    end
  end

`ifndef SAP_CTRL_JC_EN
  // Without JC the compare flag has no consumer.
  logic unused_cmp_flag;
  assign unused_cmp_flag = cmp_flag;
`endif

  assign ep     = cw[CW_EP];
  assign pc_inc = cw[CW_PC_INC];
  assign lp     = cw[CW_LP];
  assign lm     = cw[CW_LM];
  assign ce     = cw[CW_CE];
  assign li     = cw[CW_LI];
  assign ei     = cw[CW_EI];
  assign la     = cw[CW_LA];
  assign ea     = cw[CW_EA];
  assign lb     = cw[CW_LB];
  assign sub    = cw[CW_SUB];
  assign ev     = cw[CW_EV];
  assign lo     = cw[CW_LO];

  assign halted  = (mode_q == MODE_HALT);
  assign t_state = reset ? T1 : (halted ? '0 : ring);

endmodule

// File: tb/tb_sap_control_sequencer.sv
// Testbench for sap_control_sequencer: vector table of instructions,
// hand-written reset/HALT sequences, and a random invariant sweep.
module tb_sap_control_sequencer;
  import sap_ctrl_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [3:0] opcode = 4'h0;
  logic cmp_flag = 1'b0;
  always #5 clk = ~clk;

  logic ep, pc_inc, lp, lm, ce, li, ei, la, ea, lb, sub, ev, lo, halted;
  logic [5:0] t_state;

  sap_control_sequencer dut (
    .clk(clk), .reset(reset), .opcode(opcode), .cmp_flag(cmp_flag),
    .ep(ep), .pc_inc(pc_inc), .lp(lp), .lm(lm), .ce(ce), .li(li), .ei(ei),
    .la(la), .ea(ea), .lb(lb), .sub(sub), .ev(ev), .lo(lo),
    .t_state(t_state), .halted(halted)
  );

  // Observed control word in package bit order.
  logic [12:0] dut_cw;
  always_comb begin
    dut_cw = '0;
    dut_cw[CW_EP] = ep;   dut_cw[CW_PC_INC] = pc_inc; dut_cw[CW_LP] = lp;
    dut_cw[CW_LM] = lm;   dut_cw[CW_CE] = ce;         dut_cw[CW_LI] = li;
    dut_cw[CW_EI] = ei;   dut_cw[CW_LA] = la;         dut_cw[CW_EA] = ea;
    dut_cw[CW_LB] = lb;   dut_cw[CW_SUB] = sub;       dut_cw[CW_EV] = ev;
    dut_cw[CW_LO] = lo;
  end

  // Hand-built expected control words.
  localparam logic [12:0] Z      = 13'h0;
  localparam logic [12:0] B_EP   = 13'h0001;
  localparam logic [12:0] B_PCI  = 13'h0002;
  localparam logic [12:0] B_LP   = 13'h0004;
  localparam logic [12:0] B_LM   = 13'h0008;
  localparam logic [12:0] B_CE   = 13'h0010;
  localparam logic [12:0] B_LI   = 13'h0020;
  localparam logic [12:0] B_EI   = 13'h0040;
  localparam logic [12:0] B_LA   = 13'h0080;
  localparam logic [12:0] B_EA   = 13'h0100;
  localparam logic [12:0] B_LB   = 13'h0200;
  localparam logic [12:0] B_SUB  = 13'h0400;
  localparam logic [12:0] B_EV   = 13'h0800;
  localparam logic [12:0] B_LO   = 13'h1000;

  // ---------------- scoreboard ----------------
  int n_chk = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [15:0] got, input logic [15:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Drive one cycle's inputs, let decode settle, compare, then advance.
  task automatic cycle_check(input string name, input logic [3:0] op, input logic c,
                             input logic [12:0] exp_cw, input logic [5:0] exp_t);
    opcode = op;
    cmp_flag = c;
    #1;
    check({name, ".cw"}, {3'b0, dut_cw}, {3'b0, exp_cw});
    check({name, ".t"}, {10'b0, t_state}, {10'b0, exp_t});
    next_cycle();
  endtask

  task automatic run_instr(input string name, input logic [3:0] op, input logic c,
                           input logic [12:0] e4, input logic [12:0] e5, input logic [12:0] e6);
    cycle_check({name, ".T1"}, op, c, B_EP | B_LM, T1);
    cycle_check({name, ".T2"}, op, c, B_PCI, T2);
    cycle_check({name, ".T3"}, op, c, B_CE | B_LI, T3);
    cycle_check({name, ".T4"}, op, c, e4, T4);
    cycle_check({name, ".T5"}, op, c, e5, T5);
    cycle_check({name, ".T6"}, op, c, e6, T6);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    string      name;
    logic [3:0] op;
    logic       cmp;
    logic [12:0] e4, e5, e6;
  } vec_t;

  vec_t vecs[$];
  logic [12:0] jc_taken;

  initial begin
`ifdef SAP_CTRL_JC_EN
    jc_taken = B_EI | B_LP;
`else
    jc_taken = Z;
`endif
    vecs.push_back('{"LDA",   4'h0, 1'b0, B_EI | B_LM, B_CE | B_LA, Z});
    vecs.push_back('{"ADD",   4'h1, 1'b0, B_EI | B_LM, B_CE | B_LB, B_EV | B_LA});
    vecs.push_back('{"SUB",   4'h2, 1'b1, B_EI | B_LM, B_CE | B_LB | B_SUB, B_EV | B_LA | B_SUB});
    vecs.push_back('{"NOP3",  4'h3, 1'b1, Z, Z, Z});
    vecs.push_back('{"JC1",   4'h7, 1'b1, jc_taken, Z, Z});
    vecs.push_back('{"JC0",   4'h7, 1'b0, Z, Z, Z});
    vecs.push_back('{"NOP9",  4'h9, 1'b0, Z, Z, Z});
    vecs.push_back('{"OUT",   4'hE, 1'b0, B_EA | B_LO, Z, Z});

    // Reset state.
    reset = 1'b1;
    next_cycle();
    next_cycle();
    check("rst.cw", {3'b0, dut_cw}, 16'h0);
    check("rst.t", {10'b0, t_state}, {10'b0, T1});
    check("rst.halted", {15'b0, halted}, 16'h0);
    reset = 1'b0;

    // Table-driven instructions, back to back (ring wrap between each).
    foreach (vecs[i]) run_instr(vecs[i].name, vecs[i].op, vecs[i].cmp, vecs[i].e4, vecs[i].e5, vecs[i].e6);

    // HLT: fetch, T4 all zero, then stuck in HALT for 20 cycles.
    cycle_check("HLT.T1", OP_HLT, 1'b0, B_EP | B_LM, T1);
    cycle_check("HLT.T2", OP_HLT, 1'b0, B_PCI, T2);
    cycle_check("HLT.T3", OP_HLT, 1'b0, B_CE | B_LI, T3);
    cycle_check("HLT.T4", OP_HLT, 1'b0, Z, T4);
    for (int k = 0; k < 20; k++) begin
      opcode = 4'($urandom_range(0, 15));
      cmp_flag = 1'($urandom_range(0, 1));
      #1;
      check("halt.halted", {15'b0, halted}, 16'h1);
      check("halt.cw", {3'b0, dut_cw}, 16'h0);
      check("halt.t", {10'b0, t_state}, 16'h0);
      next_cycle();
    end

    // Reset from HALT.
    reset = 1'b1;
    #1;
    check("rsth.cw", {3'b0, dut_cw}, 16'h0);
    check("rsth.t", {10'b0, t_state}, {10'b0, T1});
    next_cycle();
    check("rsth.halted", {15'b0, halted}, 16'h0);
    reset = 1'b0;
    run_instr("LDA2", OP_LDA, 1'b0, B_EI | B_LM, B_CE | B_LA, Z);

    // Reset in T5 of ADD.
    cycle_check("ADDr.T1", OP_ADD, 1'b0, B_EP | B_LM, T1);
    cycle_check("ADDr.T2", OP_ADD, 1'b0, B_PCI, T2);
    cycle_check("ADDr.T3", OP_ADD, 1'b0, B_CE | B_LI, T3);
    cycle_check("ADDr.T4", OP_ADD, 1'b0, B_EI | B_LM, T4);
    reset = 1'b1;
    #1;
    check("rst5.cw", {3'b0, dut_cw}, 16'h0);
    check("rst5.t", {10'b0, t_state}, {10'b0, T1});
    next_cycle();
    reset = 1'b0;
    run_instr("SUBr", OP_SUB, 1'b0, B_EI | B_LM, B_CE | B_LB | B_SUB, B_EV | B_LA | B_SUB);

    // Random sweep: 1000 non-HLT instructions, invariants every cycle.
    for (int n = 0; n < 1000; n++) begin
      logic [3:0] op;
      op = 4'($urandom_range(0, 14));
      for (int k = 0; k < 6; k++) begin
        opcode = op;
        cmp_flag = 1'($urandom_range(0, 1));
        #1;
        check("rnd.bus", {15'b0, ((32'(ep) + 32'(ce) + 32'(ei) + 32'(ea) + 32'(ev)) <= 1)}, 16'h1);
        check("rnd.t", {10'b0, t_state}, 16'(1 << k));
`ifndef SAP_CTRL_JC_EN
        check("rnd.lp", {15'b0, lp}, 16'h0);
`endif
        next_cycle();
      end
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  // Global time bound.
  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
